// File: rtl/seg7_scan_decoder.sv
// Purpose: receive-side monitor for a multiplexed 8-digit 7-segment bus; decodes digits, assembles frames, flags errors.
// Latency: a bus value held from edge k commits on edge k+STABLE_CYCLES-1; outputs are registered and visible after that edge.
// Backpressure: none. This is a passive observer that never stalls the bus. frame_valid is a one-cycle pulse with no handshake.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   AA[7:0]          active-low anodes (bit i low selects digit i)
//   segment[6:0]     active-low segments {a,b,c,d,e,f,g}
//   clear_err        synchronous clear of the sticky error flags (a same-cycle set wins)
//   digits[31:0]     live decoded nibbles, nibble i at [4i+3:4i]
//   blank[7:0]       digit i last committed with every segment off
//   frame[31:0]      snapshot of digits captured when all 8 digits have committed
//   frame_valid      one-cycle pulse that accompanies a new frame
//   err_multi        sticky: more than one anode was stable-active at a commit
//   err_code         sticky: a stable segment pattern was neither a glyph nor blank
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  AA,
  input  logic [6:0]  segment,
  input  logic        clear_err,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [31:0] frame,
  output logic        frame_valid,
  output logic        err_multi,
  output logic        err_code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  // Returns {valid, nibble} for an active-high segment pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] sn);
    logic [4:0] r;
    case (sn)
      7'h7E:   r = 5'h10;
      7'h30:   r = 5'h11;
      7'h6D:   r = 5'h12;
      7'h79:   r = 5'h13;
      7'h33:   r = 5'h14;
      7'h5B:   r = 5'h15;
      7'h5F:   r = 5'h16;
      7'h70:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h7B:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h1F:   r = 5'h1B;
      7'h4E:   r = 5'h1C;
      7'h3D:   r = 5'h1D;
      7'h4F:   r = 5'h1E;
      7'h47:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [14:0]   prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   digits_q, digits_d;
  logic [7:0]    blank_q, blank_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   frame_q, frame_d;
  logic          frame_valid_q, frame_valid_d;
  logic          err_multi_q, err_multi_d;
  logic          err_code_q, err_code_d;

  logic [7:0]  an;
  logic [6:0]  sn;
  logic [14:0] sample;
  logic        same;
  logic        commit;
  logic        multi_hot;
  logic        one_hot;
  logic [2:0]  idx;
  logic [4:0]  glyph;
  logic        set_multi;
  logic        set_code;

  assign an     = ~AA;
  assign sn     = ~segment;
  assign sample = {an, sn};

  always_comb begin
    prev_d        = sample;
    cnt_d         = cnt_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    seen_d        = seen_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    set_multi     = 1'b0;
    set_code      = 1'b0;
    idx           = 3'd0;

    same = (sample == prev_q);
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end

    // The commit fires only on the step into saturation, so a long hold commits once.
    commit = same && (cnt_q == CNT_PRE);

    // Clearing the lowest set bit leaves something only when two or more anodes are active.
    multi_hot = ((an & (an - 8'd1)) != 8'd0);
    one_hot   = (an != 8'd0) && !multi_hot;
    for (int i = 0; i < 8; i++) begin
      if (an[i]) idx = i[2:0];
    end
    glyph = decode_glyph(sn);

    if (commit) begin
      if (multi_hot) begin
        set_multi = 1'b1;
      end else if (one_hot) begin
        if (sn == 7'h00) begin
          blank_d[idx]               = 1'b1;
          digits_d[{idx, 2'b00} +: 4] = 4'h0;
          seen_d[idx]                = 1'b1;
        end else if (glyph[4]) begin
          blank_d[idx]               = 1'b0;
          digits_d[{idx, 2'b00} +: 4] = glyph[3:0];
          seen_d[idx]                = 1'b1;
        end else begin
          set_code = 1'b1;
        end
      end
      // Frame captures the post-commit digits so the completing digit is included.
      if (seen_d == 8'hFF) begin
        frame_d       = digits_d;
        seen_d        = 8'h00;
        frame_valid_d = 1'b1;
      end
    end

    err_multi_d = set_multi | (err_multi_q & ~clear_err);
    err_code_d  = set_code  | (err_code_q  & ~clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q        <= '0;
      cnt_q         <= '0;
      digits_q      <= '0;
      blank_q       <= 8'hFF;
      seen_q        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      err_multi_q   <= 1'b0;
      err_code_q    <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      err_multi_q   <= err_multi_d;
      err_code_q    <= err_code_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign err_multi   = err_multi_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Purpose: self-checking bench for seg7_scan_decoder (table vectors, corner sequences, random scan against a reference model).
// Latency: every check is taken 1 time unit after the rising edge on which the model is stepped.
// Backpressure: not applicable; the bench drives the bus freely.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  aa;
  logic [6:0]  seg;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [31:0] frame;
  logic        frame_valid;
  logic        err_multi;
  logic        err_code;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .AA          (aa),
    .segment     (seg),
    .clear_err   (clr),
    .digits      (digits),
    .blank       (blank),
    .frame       (frame),
    .frame_valid (frame_valid),
    .err_multi   (err_multi),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fv_count = 0;

  localparam logic [6:0] GLYPH [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: the bus value's run length, per-digit nibble/blank/seen arrays.
  int          m_run;
  bit          m_first;
  logic [14:0] m_last;
  logic [3:0]  m_dig   [8];
  logic        m_blank [8];
  logic        m_seen  [8];
  logic [31:0] m_frame;
  logic        m_fv, m_em, m_ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_digits_packed();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = m_dig[i];
    return r;
  endfunction

  function automatic logic [7:0] m_blank_packed();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = m_blank[i];
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_first = 1'b1; m_last = '0;
    for (int i = 0; i < 8; i++) begin
      m_dig[i] = 4'h0; m_blank[i] = 1'b1; m_seen[i] = 1'b0;
    end
    m_frame = '0; m_fv = 1'b0; m_em = 1'b0; m_ec = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [6:0] s, input logic c);
    logic [7:0]  an;
    logic [6:0]  sn;
    logic [14:0] smp;
    int          n, id, v;
    bit          sm, sc, all;
    an = ~a; sn = ~s; smp = {an, sn};
    if (m_first || smp != m_last) m_run = 1;
    else m_run = m_run + 1;
    m_first = 1'b0;
    m_last  = smp;
    m_fv = 1'b0; sm = 1'b0; sc = 1'b0;
    if (m_run == S) begin
      n = $countones(an);
      if (n > 1) begin
        sm = 1'b1;
      end else if (n == 1) begin
        id = 0;
        for (int i = 0; i < 8; i++) if (an[i]) id = i;
        v = -1;
        for (int g = 0; g < 16; g++) if (GLYPH[g] == sn) v = g;
        if (sn == 7'h00) begin
          m_blank[id] = 1'b1; m_dig[id] = 4'h0; m_seen[id] = 1'b1;
        end else if (v >= 0) begin
          m_blank[id] = 1'b0; m_dig[id] = 4'(v); m_seen[id] = 1'b1;
        end else begin
          sc = 1'b1;
        end
        all = 1'b1;
        for (int i = 0; i < 8; i++) if (!m_seen[i]) all = 1'b0;
        if (all) begin
          m_frame = m_digits_packed();
          for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
          m_fv = 1'b1;
        end
      end
    end
    m_em = sm | (m_em & !c);
    m_ec = sc | (m_ec & !c);
  endtask

  task automatic compare_all();
    chk("model_digits",      digits,      m_digits_packed());
    chk("model_blank",       {24'h0, blank}, {24'h0, m_blank_packed()});
    chk("model_frame",       frame,       m_frame);
    chk("model_frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
    chk("model_err_multi",   {31'h0, err_multi},   {31'h0, m_em});
    chk("model_err_code",    {31'h0, err_code},    {31'h0, m_ec});
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] s, input logic c);
    aa = a; seg = s; clr = c;
    @(posedge clk);
    model_step(a, s, c);
    #1;
    if (frame_valid) fv_count++;
    compare_all();
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic c, input int n);
    repeat (n) tick(a, s, c);
  endtask

  // Asynchronous reset raised between edges; outputs must drop before any clock edge.
  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    chk("reset_digits", digits, 32'h0);
    chk("reset_blank",  {24'h0, blank}, 32'hFF);
    chk("reset_frame",  frame, 32'h0);
    chk("reset_flags",  {29'h0, frame_valid, err_multi, err_code}, 32'h0);
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  aa;
    logic [6:0]  seg;
    logic        clr;
    int          n;
    logic [31:0] e_dig;
    logic [7:0]  e_blank;
    logic [31:0] e_frame;
    logic        e_em;
    logic        e_ec;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [7:0] ra, b1, b2;
    logic [6:0] rs;
    int         kind, rn, g;

    // Frame 1: digits 0..7 show glyphs 0..7.
    tbl.push_back('{8'hFE, ~7'h7E, 1'b0, 8, 32'h00000000, 8'hFE, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hFD, ~7'h30, 1'b0, 8, 32'h00000010, 8'hFC, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hFB, ~7'h6D, 1'b0, 8, 32'h00000210, 8'hF8, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hF7, ~7'h79, 1'b0, 8, 32'h00003210, 8'hF0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hEF, ~7'h33, 1'b0, 8, 32'h00043210, 8'hE0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hDF, ~7'h5B, 1'b0, 8, 32'h00543210, 8'hC0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hBF, ~7'h5F, 1'b0, 8, 32'h06543210, 8'h80, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h7F, ~7'h70, 1'b0, 8, 32'h76543210, 8'h00, 32'h76543210, 1'b0, 1'b0});
    // Short glitch, idle, multiple anodes, clear, invalid pattern on digit 3.
    tbl.push_back('{8'hFE, ~7'h30, 1'b0, 3, 32'h76543210, 8'h00, 32'h76543210, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 7'h7F,  1'b0, 8, 32'h76543210, 8'h00, 32'h76543210, 1'b0, 1'b0});
    tbl.push_back('{8'hFC, ~7'h30, 1'b0, 6, 32'h76543210, 8'h00, 32'h76543210, 1'b1, 1'b0});
    tbl.push_back('{8'hFF, 7'h7F,  1'b1, 4, 32'h76543210, 8'h00, 32'h76543210, 1'b0, 1'b0});
    tbl.push_back('{8'hF7, ~7'h01, 1'b0, 8, 32'h76543210, 8'h00, 32'h76543210, 1'b0, 1'b1});
    // Frame 2: glyphs 8..F with digit 5 blank.
    tbl.push_back('{8'hFE, ~7'h7F, 1'b0, 8, 32'h76543218, 8'h00, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hFD, ~7'h7B, 1'b0, 8, 32'h76543298, 8'h00, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hFB, ~7'h77, 1'b0, 8, 32'h76543A98, 8'h00, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hF7, ~7'h1F, 1'b0, 8, 32'h7654BA98, 8'h00, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hEF, ~7'h4E, 1'b0, 8, 32'h765CBA98, 8'h00, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hDF, 7'h7F,  1'b0, 8, 32'h760CBA98, 8'h20, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'hBF, ~7'h4F, 1'b0, 8, 32'h7E0CBA98, 8'h20, 32'h76543210, 1'b0, 1'b1});
    tbl.push_back('{8'h7F, ~7'h47, 1'b0, 8, 32'hFE0CBA98, 8'h20, 32'hFE0CBA98, 1'b0, 1'b1});

    aa = 8'hFF; seg = 7'h7F; clr = 1'b0; reset = 1'b0;
    apply_reset();

    fv_count = 0;
    foreach (tbl[r]) begin
      hold(tbl[r].aa, tbl[r].seg, tbl[r].clr, tbl[r].n);
      chk($sformatf("tbl%0d_digits", r), digits, tbl[r].e_dig);
      chk($sformatf("tbl%0d_blank", r), {24'h0, blank}, {24'h0, tbl[r].e_blank});
      chk($sformatf("tbl%0d_frame", r), frame, tbl[r].e_frame);
      chk($sformatf("tbl%0d_errs", r), {30'h0, err_multi, err_code}, {30'h0, tbl[r].e_em, tbl[r].e_ec});
      if (r == 7)  chk("tbl_frame1_pulses", fv_count, 1);
      if (r == 19) chk("tbl_no_early_frame2", fv_count, 1);
    end
    chk("tbl_frame_pulses", fv_count, 2);

    // Commit latency: value first sampled on tick 1 commits on tick S.
    tick(8'hFE, ~7'h30, 1'b0);
    for (int t = 2; t < S; t++) tick(8'hFE, ~7'h30, 1'b0);
    chk("latency_before_commit", {28'h0, digits[3:0]}, 32'h8);
    tick(8'hFE, ~7'h30, 1'b0);
    chk("latency_at_commit", {28'h0, digits[3:0]}, 32'h1);
    hold(8'hFE, ~7'h30, 1'b0, 6);
    chk("long_hold_no_frame", fv_count, 2);
    chk("long_hold_digit", {28'h0, digits[3:0]}, 32'h1);

    // Set and clear in the same cycle: the set wins, the following clear removes it.
    hold(8'hFC, ~7'h30, 1'b1, S);
    chk("set_beats_clear", {31'h0, err_multi}, 32'h1);
    tick(8'hFF, 7'h7F, 1'b1);
    chk("clear_after_set", {30'h0, err_multi, err_code}, 32'h0);

    // Reset mid-frame discards the partial frame.
    apply_reset();
    for (int d = 0; d < 5; d++) hold(~(8'h01 << d), ~GLYPH[d], 1'b0, 6);
    apply_reset();
    fv_count = 0;
    for (int d = 0; d < 7; d++) hold(~(8'h01 << d), ~GLYPH[d + 8], 1'b0, 6);
    chk("reset_no_partial_frame", fv_count, 0);
    hold(8'h7F, ~GLYPH[15], 1'b0, 6);
    chk("reset_full_frame_pulse", fv_count, 1);
    chk("reset_full_frame_value", frame, 32'hFEDCBA98);

    // Random scan traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 11);
      if (kind == 0) begin
        ra = 8'hFF; rs = 7'($urandom_range(0, 127));
      end else if (kind == 1) begin
        b1 = 8'($urandom_range(0, 7));
        b2 = 8'((b1 + 8'($urandom_range(1, 7))) % 8);
        ra = ~((8'h01 << b1) | (8'h01 << b2));
        rs = 7'($urandom_range(0, 127));
      end else if (kind == 2) begin
        ra = ~(8'h01 << $urandom_range(0, 7));
        rs = 7'($urandom_range(0, 127));
      end else begin
        ra = ~(8'h01 << $urandom_range(0, 7));
        g  = $urandom_range(0, 16);
        rs = (g == 16) ? 7'h7F : ~GLYPH[g];
      end
      rn = $urandom_range(1, 9);
      for (int t = 0; t < rn; t++) tick(ra, rs, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
